pcs_link_ctrl: RTL

PCS_LINK_CTRL -- requirements
Module: pcs_link_ctrl

---
 rtl/pcs_link_pkg.sv | 21 ++
 rtl/pcs_link_if.sv | 24 ++
 rtl/pcs_link_timer.sv | 39 +++
 rtl/pcs_link_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pcs_link_pkg.sv
// Shared definitions for the PCS link controller: state encoding, default
// timer values and a saturating increment used by the statistics counters.
package pcs_link_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_WAIT_SD  = 3'd1,
    ST_RESTART  = 3'd2,
    ST_AN_WAIT  = 3'd3,
    ST_LINK_UP  = 3'd4
  } link_state_e;

  localparam int DEF_SD_DEBOUNCE = 1024;
  localparam int DEF_RESTART_CYC = 16;
  localparam int DEF_AN_TIMEOUT  = 1250000;  // 10 ms at 125 MHz

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pcs_link_if.sv
// PCS-facing signal bundle of the link controller: reset hold, autoneg
// enable and advertised ability toward the PCS, autoneg complete back.
interface pcs_link_if;

  logic        pcs_hold;
  logic        mr_an_enable;
  logic [16:1] mr_adv_ability;
  logic        mr_an_complete;

  modport master (
    output pcs_hold,
    output mr_an_enable,
    output mr_adv_ability,
    input  mr_an_complete
  );

  modport slave (
    input  pcs_hold,
    input  mr_an_enable,
    input  mr_adv_ability,
    output mr_an_complete
  );

endinterface

// File: rtl/pcs_link_timer.sv
// Phase timer: clearable, loadable up-counter that stops at a terminal value
// and flags it; shared by the RESTART and AN_WAIT phases.
module pcs_link_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != term)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/pcs_link_ctrl.sv
// PCS link bring-up controller: debounces signal_detect, pulses autoneg
// restart, waits for completion with timeout/retry. Define PCS_LINK_STATS_EN
// to build the link-down and autoneg-timeout statistics counters.
module pcs_link_ctrl
  import pcs_link_pkg::*;
#(
  parameter int SD_DEBOUNCE = DEF_SD_DEBOUNCE,
  parameter int RESTART_CYC = DEF_RESTART_CYC,
  parameter int AN_TIMEOUT  = DEF_AN_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_enable,
  input  logic        sw_restart,
  input  logic        signal_detect,
  input  logic [16:1] cfg_adv_ability,
  input  logic        mr_an_complete,
  output logic        pcs_hold,
  output logic        mr_an_enable,
  output logic [16:1] mr_adv_ability,
  output logic        link_up,
  output logic        link_change,
  output logic [2:0]  state,
  output logic [3:0]  retry_cnt,
  output logic [15:0] link_down_cnt,
  output logic [15:0] an_timeout_cnt
);

  localparam int SDW     = $clog2(SD_DEBOUNCE + 1);
  localparam int TMR_MAX = (AN_TIMEOUT > RESTART_CYC) ? AN_TIMEOUT : RESTART_CYC;
  localparam int TW      = $clog2(TMR_MAX) + 1;

  link_state_e state_d, state_q;
  logic [SDW-1:0] sd_cnt_d, sd_cnt_q;
  logic           sd_ok;
  logic           enter_restart, enter_an, reload, timeout, tc;
  logic [TW-1:0]  term;
  logic           pcs_hold_d, pcs_hold_q;
  logic           mr_an_enable_d, mr_an_enable_q;
  logic [16:1]    adv_d, adv_q;
  logic           link_up_d, link_up_q;
  logic           link_change_d, link_change_q;
  logic [3:0]     retry_d, retry_q;

  // The current sample counts toward the debounce, so the state change
  // lands on the edge that takes the SD_DEBOUNCE-th high sample.
  always_comb begin
    sd_cnt_d = sd_cnt_q;
    if (!signal_detect) begin
      sd_cnt_d = '0;
    end else if (sd_cnt_q != SDW'(SD_DEBOUNCE)) begin
      sd_cnt_d = sd_cnt_q + 1'b1;
    end
    sd_ok = signal_detect && (sd_cnt_q >= SDW'(SD_DEBOUNCE - 1));
  end

  always_comb begin
    state_d       = state_q;
    enter_restart = 1'b0;
    enter_an      = 1'b0;
    reload        = 1'b0;
    timeout       = 1'b0;
    if (!ctrl_enable) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_WAIT_SD;
        ST_WAIT_SD:  if (sd_ok) enter_restart = 1'b1;
        ST_RESTART, ST_AN_WAIT, ST_LINK_UP: begin
          if (!signal_detect) begin
            state_d = ST_WAIT_SD;
          end else if (sw_restart) begin
            if (state_q == ST_RESTART) reload = 1'b1;
            else                       enter_restart = 1'b1;
          end else begin
            case (state_q)
              ST_RESTART: if (tc) enter_an = 1'b1;
              ST_AN_WAIT: begin
                if (mr_an_complete) begin
                  state_d = ST_LINK_UP;
                end else if (tc) begin
                  enter_restart = 1'b1;
                  timeout       = 1'b1;
                end
              end
              ST_LINK_UP: if (!mr_an_complete) enter_restart = 1'b1;
              default: ;
            endcase
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
    if (enter_restart || reload) state_d = ST_RESTART;
    if (enter_an)                state_d = ST_AN_WAIT;
  end

  assign term = (state_q == ST_RESTART) ? TW'(RESTART_CYC - 1) : TW'(AN_TIMEOUT - 1);

  pcs_link_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (enter_restart || enter_an),
    .load     (reload),
    .load_val ('0),
    .inc      ((state_q == ST_RESTART) || (state_q == ST_AN_WAIT)),
    .term     (term),
    .tc       (tc)
  );

  // Outputs are decoded from the next state so they change together with it.
  always_comb begin
    pcs_hold_d     = (state_d == ST_DISABLED) || (state_d == ST_WAIT_SD);
    mr_an_enable_d = (state_d == ST_AN_WAIT) || (state_d == ST_LINK_UP);
    link_up_d      = (state_d == ST_LINK_UP);
    link_change_d  = link_up_d != link_up_q;
    adv_d          = (enter_restart || reload) ? cfg_adv_ability : adv_q;
    retry_d        = retry_q;
    if (state_d == ST_LINK_UP) begin
      retry_d = '0;
    end else if (timeout && (retry_q != 4'hF)) begin
      retry_d = retry_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_DISABLED;
      sd_cnt_q       <= '0;
      pcs_hold_q     <= 1'b1;
      mr_an_enable_q <= 1'b0;
      adv_q          <= '0;
      link_up_q      <= 1'b0;
      link_change_q  <= 1'b0;
      retry_q        <= '0;
    end else begin
      state_q        <= state_d;
      sd_cnt_q       <= sd_cnt_d;
      pcs_hold_q     <= pcs_hold_d;
      mr_an_enable_q <= mr_an_enable_d;
      adv_q          <= adv_d;
      link_up_q      <= link_up_d;
      link_change_q  <= link_change_d;
      retry_q        <= retry_d;
    end
  end

`ifdef PCS_LINK_STATS_EN
  logic [15:0] link_down_cnt_d, link_down_cnt_q;
  logic [15:0] an_timeout_cnt_d, an_timeout_cnt_q;
  logic        link_exit;

  always_comb begin
    link_exit        = (state_q == ST_LINK_UP) && (state_d != ST_LINK_UP);
    link_down_cnt_d  = link_exit ? sat_inc16(link_down_cnt_q) : link_down_cnt_q;
    an_timeout_cnt_d = timeout ? sat_inc16(an_timeout_cnt_q) : an_timeout_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      link_down_cnt_q  <= '0;
      an_timeout_cnt_q <= '0;
    end else begin
      link_down_cnt_q  <= link_down_cnt_d;
      an_timeout_cnt_q <= an_timeout_cnt_d;
    end
  end

  assign link_down_cnt  = link_down_cnt_q;
  assign an_timeout_cnt = an_timeout_cnt_q;
`else
  assign link_down_cnt  = '0;
  assign an_timeout_cnt = '0;
`endif

  assign state          = state_q;
  assign pcs_hold       = pcs_hold_q;
  assign mr_an_enable   = mr_an_enable_q;
  assign mr_adv_ability = adv_q;
  assign link_up        = link_up_q;
  assign link_change    = link_change_q;
  assign retry_cnt      = retry_q;

endmodule
